fpu_addsub_pipe: RTL

FPU_ADDSUB_PIPE -- requirements
Module: fpu_addsub_pipe

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fpu_lzc.sv | 19 +
 rtl/fpu_addsub_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op codes, flag bit positions, canonical NaN.
// Ports: none (package only).
package fpu_pkg;

    typedef enum logic {
        FADD_OP_ADD = 1'b0,
        FADD_OP_SUB = 1'b1
    } fadd_op_e;

    localparam int FLAGS_W = 4;
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;

    // Quiet NaN: sign 0, exponent all-ones, mantissa MSB only.
    // Returned wide; callers truncate to 1+exp_w+man_w bits.
    function automatic logic [63:0] canon_qnan(
        input int exp_w,
        input int man_w
    );
        logic [63:0] one;
        one = 64'd1;
        return (((one << exp_w) - one) << man_w)
             | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; returns WIDTH for an all-zero input.
// Ports: in_vec (WIDTH), cnt (CNT_W).
module fpu_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [CNT_W-1:0] cnt
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_vec[i]) cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// 3-stage float add/sub: align, add, normalise/round.
// Ports: valid/ready in (op, a, b, tag), valid/ready out.
module fpu_addsub_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             out_flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 4;
    localparam int SUM_W = SIG_W + 1;
    localparam int EW    = EXP_W + 2;
    localparam int LZ_W  = $clog2(SIG_W + 1);

    localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] FAR = EXP_W'(MAN_W + 3);
    localparam logic signed [EW-1:0] E_INF = EW'({2'b00, EXP_MAX});

    typedef struct packed {
        logic              sp;
        logic [W-1:0]      sp_res;
        logic [3:0]        sp_flags;
        logic              sign;
        logic              eff_sub;
        logic [EXP_W-1:0]  exp;
        logic [SIG_W-1:0]  sig_l;
        logic [SIG_W-1:0]  sig_s;
        logic [TAG_W-1:0]  tag;
    } s1_t;

    typedef struct packed {
        logic              sp;
        logic [W-1:0]      sp_res;
        logic [3:0]        sp_flags;
        logic              sign;
        logic              eff_sub;
        logic [EXP_W-1:0]  exp;
        logic [SUM_W-1:0]  sum;
        logic [TAG_W-1:0]  tag;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic v1, v2, v3;
    logic accept, ld2, ld3, adv3;

    // Handshake: each stage refills when it empties in the same cycle.
    assign adv3      = v3 & out_ready;
    assign ld3       = v2 & (~v3 | adv3);
    assign ld2       = v1 & (~v2 | ld3);
    assign in_ready  = ~v1 | ld2;
    assign accept    = in_valid & in_ready;
    assign out_valid = v3;

    // ---------------- S1: unpack, specials, align
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             inf_inf, a_big, far;
    logic [W-2:0]     mag_a, mag_b;
    logic [SIG_W-1:0] sig_a, sig_b, sig_l, sig_s_raw, sig_s;
    logic [EXP_W-1:0] exp_l, exp_s, exp_d;
    logic [2*SIG_W-1:0] wide;

    assign {sa, ea, ma} = in_a;
    assign eb = in_b[W-2:MAN_W];
    assign mb = in_b[MAN_W-1:0];
    assign sb = in_b[W-1] ^ in_op;

    assign a_nan  = (&ea) & (|ma);
    assign b_nan  = (&eb) & (|mb);
    assign a_inf  = (&ea) & ~(|ma);
    assign b_inf  = (&eb) & ~(|mb);
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);
    assign inf_inf = a_inf & b_inf & (sa ^ sb);

    // Denormals flush to zero before any comparison.
    assign mag_a = a_zero ? '0 : in_a[W-2:0];
    assign mag_b = b_zero ? '0 : in_b[W-2:0];
    assign sig_a = a_zero ? '0 : {1'b1, ma, 3'b000};
    assign sig_b = b_zero ? '0 : {1'b1, mb, 3'b000};
    assign a_big = mag_a >= mag_b;

    assign exp_l     = a_big ? ea : eb;
    assign exp_s     = a_big ? eb : ea;
    assign sig_l     = a_big ? sig_a : sig_b;
    assign sig_s_raw = a_big ? sig_b : sig_a;
    assign exp_d     = exp_l - exp_s;
    assign far       = exp_d >= FAR;

    // Bits shifted past the sticky position are ORed back into it.
    assign wide  = {sig_s_raw, {SIG_W{1'b0}}} >> exp_d;
    assign sig_s = far
        ? {{(SIG_W-1){1'b0}}, |sig_s_raw}
        : wide[2*SIG_W-1:SIG_W]
          | {{(SIG_W-1){1'b0}}, |wide[SIG_W-1:0]};

    always_comb begin
        s1_d         = '0;
        s1_d.tag     = in_tag;
        s1_d.eff_sub = sa ^ sb;
        s1_d.sign    = a_big ? sa : sb;
        s1_d.exp     = exp_l;
        s1_d.sig_l   = sig_l;
        s1_d.sig_s   = sig_s;
        if (a_nan || b_nan || inf_inf) begin
            s1_d.sp     = 1'b1;
            s1_d.sp_res = QNAN;
            s1_d.sp_flags[FLAG_NV] = inf_inf;
        end else if (a_inf) begin
            s1_d.sp     = 1'b1;
            s1_d.sp_res = {sa, EXP_MAX, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_d.sp     = 1'b1;
            s1_d.sp_res = {sb, EXP_MAX, {MAN_W{1'b0}}};
        end
    end

    // ---------------- S2: effective add/subtract
    always_comb begin
        s2_d          = '0;
        s2_d.sp       = s1_q.sp;
        s2_d.sp_res   = s1_q.sp_res;
        s2_d.sp_flags = s1_q.sp_flags;
        s2_d.sign     = s1_q.sign;
        s2_d.eff_sub  = s1_q.eff_sub;
        s2_d.exp      = s1_q.exp;
        s2_d.tag      = s1_q.tag;
        s2_d.sum      = s1_q.eff_sub
            ? {1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s}
            : {1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s};
    end

    // ---------------- S3: normalise, round, pack
    logic [LZ_W-1:0]         lz;
    logic [SIG_W-1:0]        norm;
    logic signed [EW-1:0]    e_n, e_r;
    logic                    lsb, grd, stk, rnd_up;
    logic [MAN_W+1:0]        rnd;
    logic [MAN_W-1:0]        frac;
    logic [W-1:0]            res;
    logic [3:0]              flags;

    fpu_lzc #(
        .WIDTH (SIG_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .in_vec (s2_q.sum[SIG_W-1:0]),
        .cnt    (lz)
    );

    always_comb begin
        if (s2_q.sum[SUM_W-1]) begin
            norm = s2_q.sum[SUM_W-1:1]
                 | {{(SIG_W-1){1'b0}}, s2_q.sum[0]};
            e_n  = EW'({2'b00, s2_q.exp}) + EW'(1);
        end else begin
            norm = s2_q.sum[SIG_W-1:0] << lz;
            e_n  = EW'({2'b00, s2_q.exp}) - EW'(lz);
        end
    end

    assign lsb    = norm[3];
    assign grd    = norm[2];
    assign stk    = norm[1] | norm[0];
    assign rnd_up = grd & (stk | lsb);
    assign rnd    = {1'b0, norm[SIG_W-1:3]} + (MAN_W+2)'(rnd_up);
    assign e_r    = e_n + EW'(rnd[MAN_W+1]);
    assign frac   = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

    always_comb begin
        res   = '0;
        flags = '0;
        if (s2_q.sp) begin
            res   = s2_q.sp_res;
            flags = s2_q.sp_flags;
        end else if (s2_q.sum == '0) begin
            // Cancellation gives +0; only -0 + -0 keeps the sign.
            res[W-1] = s2_q.sign & ~s2_q.eff_sub;
        end else if (e_r >= E_INF) begin
            res = {s2_q.sign, EXP_MAX, {MAN_W{1'b0}}};
            flags[FLAG_OF] = 1'b1;
            flags[FLAG_NX] = 1'b1;
        end else if (e_r <= 0) begin
            res[W-1] = s2_q.sign;
            flags[FLAG_UF] = 1'b1;
            flags[FLAG_NX] = 1'b1;
        end else begin
            res = {s2_q.sign, e_r[EXP_W-1:0], frac};
            flags[FLAG_NX] = grd | stk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else begin
            if (accept) s1_q <= s1_d;
            if (ld2) s2_q <= s2_d;
            if (ld3) begin
                out_result <= res;
                out_tag    <= s2_q.tag;
                out_flags  <= flags;
            end
            v1 <= accept | (v1 & ~ld2);
            v2 <= ld2 | (v2 & ~ld3);
            v3 <= ld3 | (v3 & ~adv3);
        end
    end

endmodule
